// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port arbiter bus: core writeback, accelerator FIFO input,
// hazard lookup and the registered register-file write port.
interface regfile_wr_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) ();
  logic                   core_we;
  logic [4:0]             core_rd;
  logic [DATA_W-1:0]      core_wdata;
  logic                   core_stall;

  logic                   acc_valid;
  logic                   acc_ready;
  logic [4:0]             acc_rd;
  logic [DATA_W-1:0]      acc_wdata;

  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic                   busy1;
  logic                   busy2;

  logic                   rf_we;
  logic [4:0]             rf_rd;
  logic [DATA_W-1:0]      rf_wdata;
  logic [$clog2(DEPTH):0] fifo_count;

  modport slave (
    input  core_we, core_rd, core_wdata,
    input  acc_valid, acc_rd, acc_wdata,
    input  rs1, rs2,
    output core_stall, acc_ready, busy1, busy2,
    output rf_we, rf_rd, rf_wdata, fifo_count
  );

  modport master (
    output core_we, core_rd, core_wdata,
    output acc_valid, acc_rd, acc_wdata,
    output rs1, rs2,
    input  core_stall, acc_ready, busy1, busy2,
    input  rf_we, rf_rd, rf_wdata, fifo_count
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between core writeback (priority) and a
// buffered accelerator result path, with a starvation guarantee and RAW busy flags.
module regfile_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + SW'(1);
  endfunction

  // Slot idx holds a buffered write when its distance from the head is below the count.
  function automatic logic entry_live(input logic [AW-1:0] idx,
                                      input logic [AW-1:0] head,
                                      input logic [CW-1:0] cnt);
    logic [AW-1:0] off;
    off = idx - head;
    return {1'b0, off} < cnt;
  endfunction

  logic [4:0]        q_rd   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;
  logic [SW-1:0]     starve_nxt;
  logic              ready_en;

  logic              core_req_p0;
  logic              fifo_ne_p0;
  logic              full_p0;
  logic              force_acc_p0;
  logic              grant_core_p0;
  logic              grant_acc_p0;
  logic              acc_ready_p0;
  logic              push_p0;

  logic              vld_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic              hit1;
  logic              hit2;

  // ---- stage p0: arbitration on the current FIFO head ----
  always_comb begin
    core_req_p0   = bus.core_we && (bus.core_rd != 5'd0);
    fifo_ne_p0    = (count != '0);
    full_p0       = (count == FULL_CNT);
    force_acc_p0  = (starve_cnt == LIMIT) && fifo_ne_p0;
    grant_acc_p0  = force_acc_p0 || (!core_req_p0 && fifo_ne_p0);
    grant_core_p0 = core_req_p0 && !force_acc_p0;
    acc_ready_p0  = ready_en && !full_p0;
    push_p0       = bus.acc_valid && acc_ready_p0 && (bus.acc_rd != 5'd0);
  end

  // Any cycle that is not a core grant behind a non-empty FIFO clears the counter.
  always_comb begin
    starve_nxt = '0;
    if (grant_core_p0 && fifo_ne_p0)
      starve_nxt = sat_inc(starve_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      starve_cnt <= starve_nxt;
      if (push_p0)
        wr_ptr <= wr_ptr + AW'(1);
      if (grant_acc_p0)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_p0) - CW'(grant_acc_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      q_rd[wr_ptr]   <= bus.acc_rd;
      q_data[wr_ptr] <= bus.acc_wdata;
    end
  end

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      rd_p1    <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= grant_core_p0 || grant_acc_p0;
      if (grant_core_p0) begin
        rd_p1    <= bus.core_rd;
        wdata_p1 <= bus.core_wdata;
      end else if (grant_acc_p0) begin
        rd_p1    <= q_rd[rd_ptr];
        wdata_p1 <= q_data[rd_ptr];
      end
    end
  end

  // Pending writes are those still buffered plus the one on the write port.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live(AW'(i), rd_ptr, count)) begin
        if (q_rd[i] == bus.rs1) hit1 = 1'b1;
        if (q_rd[i] == bus.rs2) hit2 = 1'b1;
      end
    end
    if (vld_p1 && (rd_p1 == bus.rs1)) hit1 = 1'b1;
    if (vld_p1 && (rd_p1 == bus.rs2)) hit2 = 1'b1;
  end

  assign bus.core_stall = core_req_p0 && force_acc_p0;
  assign bus.acc_ready  = acc_ready_p0;
  assign bus.busy1      = (bus.rs1 != 5'd0) && hit1;
  assign bus.busy2      = (bus.rs2 != 5'd0) && hit2;
  assign bus.rf_we      = vld_p1;
  assign bus.rf_rd      = rd_p1;
  assign bus.rf_wdata   = wdata_p1;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed test-plan steps then random traffic,
// all compared each cycle against a queue-based reference model.
module tb_regfile_wr_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset_n;

  regfile_wr_arbiter_if #(.DEPTH(DEPTH), .DATA_W(32)) bus ();

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  wr_t         q[$];
  int          starve;
  bit          m_ready;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          exp_stall_last;
  bit          exp_ready_last;
  logic        obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_busy(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return m_we && (m_rd == rs);
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit cw, input logic [4:0] crd, input logic [31:0] cd,
                       input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit creq, forced, e_stall, e_ready, push, n_we;
    logic [4:0]  n_rd;
    logic [31:0] n_data;
    wr_t head;
    bus.core_we = cw;  bus.core_rd = crd; bus.core_wdata = cd;
    bus.acc_valid = av; bus.acc_rd = ard; bus.acc_wdata = ad;
    bus.rs1 = r1; bus.rs2 = r2;
    #1;
    creq    = cw && (crd != 5'd0);
    forced  = (starve == STARVE_LIMIT) && (q.size() > 0);
    e_stall = creq && forced;
    e_ready = m_ready && (q.size() < DEPTH);
    chk("core_stall", 32'(bus.core_stall), 32'(e_stall));
    chk("acc_ready",  32'(bus.acc_ready),  32'(e_ready));
    chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    chk("busy1",      32'(bus.busy1),      32'(model_busy(r1)));
    chk("busy2",      32'(bus.busy2),      32'(model_busy(r2)));
    chk("rf_we",      32'(bus.rf_we),      32'(m_we));
    if (m_we) begin
      chk("rf_rd",    32'(bus.rf_rd),      32'(m_rd));
      chk("rf_wdata", bus.rf_wdata,        m_data);
    end
    obs_stall      = bus.core_stall;
    exp_stall_last = e_stall;
    exp_ready_last = e_ready;
    push = av && e_ready && (ard != 5'd0);
    n_we = 1'b0; n_rd = m_rd; n_data = m_data;
    if (q.size() > 0 && (forced || !creq)) begin
      head = q.pop_front();
      n_we = 1'b1; n_rd = head.rd; n_data = head.data;
      starve = 0;
    end else if (creq) begin
      n_we = 1'b1; n_rd = crd; n_data = cd;
      starve = (q.size() > 0) ? ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT) : 0;
    end else begin
      starve = 0;
    end
    if (push) q.push_back('{ard, ad});
    @(posedge clk);
    m_we = n_we; m_rd = n_rd; m_data = n_data; m_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; released just after a falling edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rf_we",      32'(bus.rf_we),      0);
    chk("rst_rf_rd",      32'(bus.rf_rd),      0);
    chk("rst_rf_wdata",   bus.rf_wdata,        0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 0);
    chk("rst_acc_ready",  32'(bus.acc_ready),  0);
    q.delete();
    starve = 0; m_we = 0; m_rd = '0; m_data = '0; m_ready = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int stalls;
    int stale;
    bit cw, av;
    logic [4:0]  crd, ard, r1, r2;
    logic [31:0] cd, ad;

    reset_n = 1'b1;
    bus.core_we = 0; bus.core_rd = 0; bus.core_wdata = 0;
    bus.acc_valid = 0; bus.acc_rd = 0; bus.acc_wdata = 0;
    bus.rs1 = 0; bus.rs2 = 0;
    exp_stall_last = 0; exp_ready_last = 0;

    // reset and release: acc_ready rises one cycle after release
    do_reset();
    idle(2);

    // core alone
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    chk("core_rf_rd",    32'(bus.rf_rd), 5);
    chk("core_rf_wdata", bus.rf_wdata,   32'hDEADBEEF);
    idle(1);

    // accelerator fill while the core is writing continuously
    for (int i = 1; i <= 5; i++)
      cycle(1, 20, 32'h2000_0000 + i, 1, 5'(i), 32'hA000_0000 + i, 5'(i), 20);
    chk("fill_count", 32'(bus.fifo_count), 4);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 20, 32'h2000_00FF, 0, 0, 0, 1, 2);
      if (obs_stall === 1'b1) begin
        stalls++;
        chk("forced_rd", 32'(bus.rf_rd), 1);
      end
    end
    chk("stall_cycles", stalls, 1);
    idle(6);

    // drain order and pointer wrap
    cycle(0, 0, 0, 1, 10, 32'h0000_0010, 10, 11);
    cycle(0, 0, 0, 1, 11, 32'h0000_0011, 11, 12);
    cycle(0, 0, 0, 1, 12, 32'h0000_0012, 12, 10);
    idle(3);
    for (int i = 0; i < 4; i++)
      cycle(1, 3, 32'h3333_0000 + i, 1, 5'(13 + i), 32'hC0DE_0000 + i, 5'(13 + i), 3);
    idle(6);

    // hazard flags, and acc_rd==0 accepted but dropped
    cycle(1, 9, 32'h9, 1, 7, 32'h7777_7777, 7, 0);
    chk("haz_busy1", 32'(bus.busy1), 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 7, 0);
    cycle(0, 0, 0, 1, 0, 32'h1234_5678, 7, 0);
    idle(2);

    // reset mid-drain
    do_reset();
    idle(1);
    cycle(1, 4, 32'h44, 1, 10, 32'hB10, 10, 0);
    cycle(1, 4, 32'h45, 1, 11, 32'hB11, 11, 0);
    cycle(1, 4, 32'h46, 1, 12, 32'hB12, 12, 0);
    chk("pre_reset_count", 32'(bus.fifo_count), 3);
    chk("pre_reset_we",    32'(bus.rf_we),      1);
    do_reset();
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 10, 12);
      if (bus.rf_we === 1'b1 && bus.rf_rd >= 10 && bus.rf_rd <= 12) stale++;
    end
    chk("stale_writes", stale, 0);

    // random traffic; stalled core and refused accelerator hold their request
    cw = 0; av = 0; crd = 0; ard = 0; cd = 0; ad = 0;
    exp_stall_last = 0;
    for (int n = 0; n < 400; n++) begin
      if (!exp_stall_last) begin
        cw  = ($urandom_range(0, 9) < 8);
        crd = 5'($urandom_range(0, 7));
        cd  = $urandom;
      end
      if (!(av && !exp_ready_last)) begin
        av  = ($urandom_range(0, 2) != 0);
        ard = 5'($urandom_range(0, 7));
        ad  = $urandom;
      end
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      cycle(cw, crd, cd, av, ard, ad, r1, r2);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
